rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 109 ++++++++++
 tb/tb_rr_arbiter4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time.
// A grant is held until done, a dropped request, or HOLD_MAX cycles, then one idle cycle follows.
module rr_arbiter4 #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   state_t     state_reg;
   logic [1:0] ptr_reg;
   logic [1:0] owner_reg;
   logic [7:0] cnt_reg;

   logic [3:0] rot_req;
   logic [1:0] win_off;
   logic [1:0] win_idx;
   logic [3:0] win_onehot;
   logic       owner_drop;
   logic       hold_expired;
   logic       release_now;

   // rot_req[k] is the request k places after the pointer, so the lowest set bit wins.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign rot_req[gi] = req[ptr_reg + 2'(gi)];
      end
   endgenerate

   always_comb begin
      win_off = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (rot_req[k]) begin
            win_off = 2'(k);
         end
      end
   end

   assign win_idx = ptr_reg + win_off;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign win_onehot[gi] = (win_idx == 2'(gi));
      end
   endgenerate

   assign owner_drop   = ~req[owner_reg];
   assign hold_expired = (cnt_reg == HOLD_LIM);
   assign release_now  = done | owner_drop | hold_expired;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         gnt       <= 4'b0000;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         ptr_reg   <= 2'd0;
         owner_reg <= 2'd0;
         cnt_reg   <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               timeout <= 1'b0;
               if (|req) begin
                  state_reg <= GRANT;
                  gnt       <= win_onehot;
                  busy      <= 1'b1;
                  owner_reg <= win_idx;
                  cnt_reg   <= 8'd1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state_reg <= IDLE;
                  gnt       <= 4'b0000;
                  busy      <= 1'b0;
                  // Only a pure hold expiry is flagged; a coincident done or drop is a normal release.
                  timeout   <= hold_expired & ~done & ~owner_drop;
                  ptr_reg   <= owner_reg + 2'd1;
                  cnt_reg   <= 8'd0;
               end else begin
                  timeout <= 1'b0;
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
               gnt       <= 4'b0000;
               busy      <= 1'b0;
               timeout   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand sequences, randomized run vs model.
module tb_rr_arbiter4;

   localparam int HOLD = 15;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;

   int checks   = 0;
   int failures = 0;
   bit started  = 0;

   rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner is the granted requester index, or -1 when nobody holds the grant.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   bit m_to    = 0;

   function automatic logic [3:0] m_gnt();
      return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
   endfunction

   task automatic model_edge(input bit r, input logic [3:0] q, input bit d);
      if (!r) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_to = 0;
      end else if (m_owner < 0) begin
         m_to = 0;
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && q[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
         end
         if (m_owner >= 0) m_held = 1;
      end else begin
         m_to = 0;
         if (d || !q[m_owner] || m_held == HOLD) begin
            m_to    = (m_held == HOLD) && !d && q[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic step(input bit r, input logic [3:0] q, input bit d);
      @(negedge clk);
      rst_n = r; req = q; done = d;
      @(posedge clk);
      model_edge(r, q, d);
      #1;
      started = 1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] eg, input bit eb, input bit et);
      checks++;
      if ({gnt, busy, timeout} !== {eg, eb, et}) begin
         failures++;
         $display("FAIL %s: got gnt=%b busy=%b timeout=%b, required gnt=%b busy=%b timeout=%b",
                  name, gnt, busy, timeout, eg, eb, et);
      end
   endtask

   // Structural invariant every cycle: zero-or-one-hot grant, busy mirrors grant.
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (!$onehot0(gnt) || (busy !== (gnt != 4'b0000))) begin
            failures++;
            $display("FAIL invariant: got gnt=%b busy=%b, required one-hot-or-zero gnt with busy=|gnt", gnt, busy);
         end
      end
   end

   typedef struct {
      bit         r;
      logic [3:0] q;
      bit         d;
      logic [3:0] eg;
      bit         eb;
      bit         et;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0; req = 4'b0000; done = 1'b0;

      // Full rotation with done one cycle after each grant, then a mid-grant drop and a mid-grant reset.
      vecs = '{
         '{0, 4'b0000, 0, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0001, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0010, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0100, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b1000, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0001, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0010, 1, 0},
         '{1, 4'b1000, 0, 4'b0000, 0, 0},
         '{1, 4'b1000, 0, 4'b1000, 1, 0},
         '{1, 4'b1000, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 1, 4'b0001, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0010, 1, 0},
         '{0, 4'b1111, 1, 4'b0000, 0, 0},
         '{1, 4'b1111, 0, 4'b0001, 1, 0},
         '{1, 4'b1111, 1, 4'b0000, 0, 0}
      };
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].q, vecs[i].d);
         expect_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eb, vecs[i].et);
      end

      // Hold expiry: 15 cycles of grant, then one timeout cycle, then re-grant.
      step(1, 4'b0100, 0);
      expect_out("hold_first", 4'b0100, 1, 0);
      for (int i = 1; i < HOLD; i++) begin
         step(1, 4'b0100, 0);
         expect_out($sformatf("hold_c%0d", i + 1), 4'b0100, 1, 0);
      end
      step(1, 4'b0100, 0);
      expect_out("hold_timeout", 4'b0000, 0, 1);
      step(1, 4'b0100, 0);
      expect_out("hold_regrant", 4'b0100, 1, 0);

      // done coinciding with hold expiry is a normal release.
      for (int i = 1; i < HOLD; i++) step(1, 4'b0100, 0);
      expect_out("coinc_pre", 4'b0100, 1, 0);
      step(1, 4'b0100, 1);
      expect_out("coinc_release", 4'b0000, 0, 0);

      // Request drop coinciding with hold expiry: also no timeout.
      step(1, 4'b0100, 0);
      expect_out("drop_grant", 4'b0100, 1, 0);
      for (int i = 1; i < HOLD; i++) step(1, 4'b0100, 0);
      step(1, 4'b0000, 0);
      expect_out("drop_release", 4'b0000, 0, 0);

      // done while idle is ignored.
      step(1, 4'b0000, 1);
      expect_out("idle_done", 4'b0000, 0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] q;
         bit r, d;
         q = req;
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) q[b] = ~q[b];
         d = ($urandom_range(0, 11) == 0);
         r = ($urandom_range(0, 299) != 0);
         step(r, q, d);
         expect_out($sformatf("rand%0d", i), m_gnt(), m_owner >= 0, m_to);
      end

      started = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
